lcd_controller: RTL and testbench
=================================

LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 Parameter LCD_SCREEN_WIDTH, default 480: active pixels per line.
REQ-002 Parameter LCD_SCREEN_HEIGHT, default 272: active lines per frame.
REQ-003 Parameters H_FRONT_PORCH=8, H_SYNC=4, H_BACK_PORCH=43, V_FRONT_PORCH=8, V_SYNC=4, V_BACK_PORCH=12: blanking widths in pixels and lines.
REQ-004 clk  in  1  pixel clock; the only clock in the block.
REQ-005 reset_p  in  1  synchronous, active-high reset.
REQ-006 queue_data_in  in  17  FIFO read data; bit16 = frame-start marker, bits 15:0 = RGB565 pixel (R=15:11, G=10:5, B=4:0).
REQ-007 queue_empty  in  1  FIFO empty flag.
REQ-008 queue_rd_en  out  1  FIFO pop request; data is valid on queue_data_in one cycle later.
REQ-009 queue_clk  out  1  FIFO read clock, driven directly from clk.
REQ-010 LCD_DE  out  1  data enable, high during active pixels.
REQ-011 LCD_HSYNC / LCD_VSYNC  out  1 each  sync pulses, active low.
REQ-012 LCD_R  out  5; LCD_G  out  6; LCD_B  out  5  pixel colour.

Function
REQ-013 Free-running counters: h_cnt 0..H_TOTAL-1 with H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP (535 at defaults); v_cnt increments on h_cnt wrap and runs 0..V_TOTAL-1 (296 at defaults); both wrap to 0.
REQ-014 Per-axis order: active region first (0..size-1), then front porch, then sync, then back porch.
REQ-015 LCD_DE, LCD_HSYNC and LCD_VSYNC are decoded from the counters and delayed by exactly 2 register stages, so they align with pixel data.
REQ-016 Word-sync state machine, reset state SEARCH.
- SEARCH: pop whenever !queue_empty; each popped word is examined on the following cycle. bit16=0 is discarded. bit16=1 goes to ARMED; the marker itself carries no pixel.
- ARMED: no pops; go to STREAM on the cycle the counter is at (h=0, v=0).
- STREAM: pop exactly one word per counter-active pixel.
REQ-017 STREAM ends after the pop for the last active pixel (h=W-1, v=H-1); the state then returns to SEARCH to consume the next frame's marker during vertical blanking.
REQ-018 Pixel path: LCD_R/G/B are registered from queue_data_in on the cycle after a STREAM pop. Every non-active or non-STREAM cycle outputs 0.
REQ-019 Underrun: queue_empty during a STREAM active pixel gives no pop, outputs black for that pixel, and moves the state to SEARCH immediately, so the rest of the frame is black.
REQ-020 A word with bit16=1 popped in STREAM is displayed as black and moves the state to ARMED (resync at next frame start).
REQ-021 queue_rd_en is never asserted while queue_empty=1 and never asserted in ARMED.

Reset
REQ-022 While reset_p=1 at a clk edge, the following are all cleared:
- h_cnt and v_cnt to 0;
- state to SEARCH;
- pipeline registers;
- queue_rd_en to 0, LCD_DE to 0, LCD_HSYNC to 1, LCD_VSYNC to 1, LCD_R/G/B to 0.
REQ-023 Reset asserted mid-frame aborts the frame. Timing restarts at (0,0) on the first cycle after release, and a new marker is required before any pixel is shown.

Configuration
REQ-024 Macro LCD_TEST_PATTERN_EN.
- Defined: the queue is ignored, queue_rd_en is held 0, and the active area shows 8 vertical colour bars of WIDTH/8 pixels (60 at defaults), left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (RGB565). Same 2-cycle alignment as REQ-015.
- Undefined: queue-driven behaviour per REQ-016..021.

Verification
REQ-025 After reset release, count cycles between VSYNC falling edges: 535*296 = 158360; HSYNC low 4 cycles; DE high 480 cycles per line on 272 lines.
REQ-026 FIFO model holds marker 0x10000 followed by 130560 words of 0x0F800: every DE pixel shows R=31, G=0, B=0, and no pop occurs in blanking after the frame.
REQ-027 FIFO holds 3 junk words (bit16=0), then a marker, then pixels 0x0001,0x0002,...: the junk is discarded, and the first DE pixel of the next frame is B=1, the second is B=2.
REQ-028 queue_empty forced high at line 10, pixel 100 of a streaming frame: the remainder of that frame is black, no pop occurs while empty, and the next marker restarts streaming in the following frame.
REQ-029 reset_p pulsed for 1 cycle mid-line: outputs take their reset values on the next edge, h_cnt/v_cnt restart from 0, and pixels reappear only after a marker.
REQ-030 With LCD_TEST_PATTERN_EN defined: pixel 0 = FFFF, pixel 60 = FFE0, pixel 479 = 0000, and queue_rd_en stays 0 throughout.

Source files
------------

// File: rtl/lcd_controller.sv
// RGB565 LCD timing generator fed from a FIFO whose frames start with a bit16 marker.
// Defining LCD_TEST_PATTERN_EN ignores the FIFO and shows eight vertical colour bars.
module lcd_controller #(
   parameter int LCD_SCREEN_WIDTH  = 480,
   parameter int LCD_SCREEN_HEIGHT = 272,
   parameter int H_FRONT_PORCH     = 8,
   parameter int H_SYNC            = 4,
   parameter int H_BACK_PORCH      = 43,
   parameter int V_FRONT_PORCH     = 8,
   parameter int V_SYNC            = 4,
   parameter int V_BACK_PORCH      = 12
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic [16:0] queue_data_in,
   input  logic        queue_empty,
   output logic        queue_rd_en,
   output logic        queue_clk,
   output logic        LCD_DE,
   output logic        LCD_HSYNC,
   output logic        LCD_VSYNC,
   output logic [4:0]  LCD_R,
   output logic [5:0]  LCD_G,
   output logic [4:0]  LCD_B
);
   localparam int H_TOTAL = LCD_SCREEN_WIDTH + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
   localparam int V_TOTAL = LCD_SCREEN_HEIGHT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT  = HW'(LCD_SCREEN_WIDTH);
   localparam logic [HW-1:0] H_LAST = HW'(LCD_SCREEN_WIDTH - 1);
   localparam logic [HW-1:0] H_SS   = HW'(LCD_SCREEN_WIDTH + H_FRONT_PORCH);
   localparam logic [HW-1:0] H_SE   = HW'(LCD_SCREEN_WIDTH + H_FRONT_PORCH + H_SYNC);
   localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(LCD_SCREEN_HEIGHT);
   localparam logic [VW-1:0] V_LAST = VW'(LCD_SCREEN_HEIGHT - 1);
   localparam logic [VW-1:0] V_SS   = VW'(LCD_SCREEN_HEIGHT + V_FRONT_PORCH);
   localparam logic [VW-1:0] V_SE   = VW'(LCD_SCREEN_HEIGHT + V_FRONT_PORCH + V_SYNC);
   localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          h_last, v_last, active, hs_n, vs_n;
   logic          de1_q, hs1_q, vs1_q, de_q, hs_q, vs_q;
   logic [15:0]   pix_d, pix_q;

   always_comb begin
      h_last  = (h_cnt_q == H_MAX);
      v_last  = (v_cnt_q == V_MAX);
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_n    = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
      vs_n    = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
   end

   // Two stages on the control path line up with FIFO read latency plus the pixel register.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         de_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         pix_q   <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         de1_q   <= active;
         hs1_q   <= hs_n;
         vs1_q   <= vs_n;
         de_q    <= de1_q;
         hs_q    <= hs1_q;
         vs_q    <= vs1_q;
         pix_q   <= pix_d;
      end
   end

`ifdef LCD_TEST_PATTERN_EN
   localparam int BAR_W = LCD_SCREEN_WIDTH / 8;

   logic [2:0]  bar;
   logic [15:0] bar_rgb, pat_q;
   logic        unused_queue;

   assign unused_queue = ^{queue_data_in, queue_empty};
   assign queue_rd_en  = 1'b0;
   assign pix_d        = pat_q;

   always_comb begin
      bar     = '0;
      bar_rgb = '0;
      for (int i = 1; i < 8; i++)
         if (h_cnt_q >= HW'(i * BAR_W)) bar = 3'(i);
      unique case (bar)
         3'd0: bar_rgb = 16'hFFFF;
         3'd1: bar_rgb = 16'hFFE0;
         3'd2: bar_rgb = 16'h07FF;
         3'd3: bar_rgb = 16'h07E0;
         3'd4: bar_rgb = 16'hF81F;
         3'd5: bar_rgb = 16'hF800;
         3'd6: bar_rgb = 16'h001F;
         3'd7: bar_rgb = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_p) pat_q <= '0;
      else         pat_q <= active ? bar_rgb : '0;
   end
`else
   typedef enum logic [1:0] {SEARCH, ARMED, STREAM} state_t;

   state_t state_q, state_d;
   logic   pop_q, spop_q, spop, rd, marker_seen;

   always_comb begin
      state_d     = state_q;
      rd          = 1'b0;
      spop        = 1'b0;
      marker_seen = pop_q && queue_data_in[16];
      // A marker under examination holds off the next pop so its successor is not lost.
      unique case (state_q)
         SEARCH: begin
            rd = !queue_empty && !marker_seen;
            if (marker_seen) state_d = ARMED;
         end
         ARMED: begin
            if (h_last && v_last) state_d = STREAM;
         end
         STREAM: begin
            if (marker_seen) begin
               state_d = ARMED;
            end else if (active) begin
               if (queue_empty) begin
                  state_d = SEARCH;
               end else begin
                  rd   = 1'b1;
                  spop = 1'b1;
                  if (h_cnt_q == H_LAST && v_cnt_q == V_LAST) state_d = SEARCH;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
      pix_d = (pop_q && spop_q && !queue_data_in[16]) ? queue_data_in[15:0] : '0;
   end

   assign queue_rd_en = rd && !reset_p;

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q <= SEARCH;
         pop_q   <= 1'b0;
         spop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pop_q   <= queue_rd_en;
         spop_q  <= spop;
      end
   end
`endif

   assign queue_clk = clk;
   assign LCD_DE    = de_q;
   assign LCD_HSYNC = hs_q;
   assign LCD_VSYNC = vs_q;
   assign LCD_R     = pix_q[15:11];
   assign LCD_G     = pix_q[10:5];
   assign LCD_B     = pix_q[4:0];
endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: small screen geometry, FIFO model and frame-level image model.
// Expected outputs come from cycle index arithmetic and per-frame image queues.
module tb_lcd_controller;
   localparam int W = 16, H = 4;
   localparam int HFP = 2, HS = 3, HBP = 4;
   localparam int VFP = 2, VS = 2, VBP = 2;
   localparam int HT = W + HFP + HS + HBP;
   localparam int VT = H + VFP + VS + VBP;
   localparam int FT = HT * VT;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        reset_p;
   logic [16:0] queue_data_in;
   logic        queue_empty;
   logic        queue_rd_en, queue_clk;
   logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
   logic [4:0]  LCD_R, LCD_B;
   logic [5:0]  LCD_G;

   always #5 clk = ~clk;

   lcd_controller #(
      .LCD_SCREEN_WIDTH(W), .LCD_SCREEN_HEIGHT(H),
      .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
      .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP)
   ) dut (
      .clk(clk), .reset_p(reset_p),
      .queue_data_in(queue_data_in), .queue_empty(queue_empty),
      .queue_rd_en(queue_rd_en), .queue_clk(queue_clk),
      .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
      .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
   );

   int vectors = 0, miscompares = 0;
   int n = 0, pops = 0, fe_lo = 0, fe_hi = 0;
   logic pend = 1'b0;
   logic [16:0] q[$];
   logic [15:0] img1[NPIX], img2[NPIX];
   int f1 = -1, f2 = -1, cut1 = 0, cut2 = 0;

   function automatic int cyc(int k);
      return (k - 2) % FT;
   endfunction

   function automatic logic exp_de(int k);
      if (k < 2) return 1'b0;
      return ((cyc(k) % HT) < W) && ((cyc(k) / HT) < H);
   endfunction

   function automatic logic exp_hs(int k);
      int h;
      if (k < 2) return 1'b1;
      h = cyc(k) % HT;
      return !(h >= W + HFP && h < W + HFP + HS);
   endfunction

   function automatic logic exp_vs(int k);
      int v;
      if (k < 2) return 1'b1;
      v = cyc(k) / HT;
      return !(v >= H + VFP && v < H + VFP + VS);
   endfunction

   function automatic logic [15:0] exp_pix(int k);
      int c, idx, f, b;
      logic [15:0] bars [8];
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      if (!exp_de(k)) return 16'h0;
      c   = cyc(k);
      idx = (c / HT) * W + (c % HT);
      f   = (k - 2) / FT;
      b   = (c % HT) / (W / 8);
      if (b > 7) b = 7;
`ifdef LCD_TEST_PATTERN_EN
      return bars[b];
`else
      if (f == f1 && idx < cut1) return img1[idx];
      if (f == f2 && idx < cut2) return img2[idx];
      return 16'h0;
`endif
   endfunction

   // One clock: FIFO pops land #1 after the edge, outputs are read at the falling edge.
   task automatic step(input logic rst);
      logic re;
      @(posedge clk);
      re = reset_p;
      #1;
      n = re ? 0 : n + 1;
      if (pend && q.size() > 0) begin
         queue_data_in = q.pop_front();
         pops++;
      end
      reset_p = rst;
      queue_empty = (n >= fe_lo && n < fe_hi) || (q.size() == 0);
      @(negedge clk);
      pend = queue_rd_en;
   endtask

   task automatic test_reset();
      step(1);
      for (int i = 0; i < 4; i++) q.push_back(17'(i + 5));
      step(1);
      step(1);
      vectors += 2;
      if ({queue_rd_en, LCD_DE, LCD_HSYNC, LCD_VSYNC} !== 4'b0011) begin
         miscompares++;
         $display("FAIL reset_ctl got %b exp 0011",
                  {queue_rd_en, LCD_DE, LCD_HSYNC, LCD_VSYNC});
      end
      if ({LCD_R, LCD_G, LCD_B} !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_pix got %h exp 0000", {LCD_R, LCD_G, LCD_B});
      end
      q.delete();
   endtask

   task automatic test_timing();
      int last_fall, hs_run, de_cnt;
      logic vs_prev, hs_prev;
      step(1);
      q.delete();
      f1 = -1; f2 = -1;
      step(1); step(0);
      last_fall = -1; hs_run = 0; de_cnt = 0;
      vs_prev = 1'b1; hs_prev = 1'b1;
      for (int i = 0; i < 2 * FT + 40; i++) begin
         vectors += 2;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== {exp_de(n), exp_hs(n), exp_vs(n)}) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL timing n=%0d got %b exp %b", n,
                        {LCD_DE, LCD_HSYNC, LCD_VSYNC}, {exp_de(n), exp_hs(n), exp_vs(n)});
         end
         if (queue_rd_en !== 1'b0) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL idle_pop n=%0d got %b exp 0", n, queue_rd_en);
         end
         if (vs_prev && !LCD_VSYNC) begin
            if (last_fall >= 0) begin
               vectors += 2;
               if (n - last_fall !== FT) begin
                  miscompares++;
                  $display("FAIL vsync_period got %0d exp %0d", n - last_fall, FT);
               end
               if (de_cnt !== NPIX) begin
                  miscompares++;
                  $display("FAIL de_per_frame got %0d exp %0d", de_cnt, NPIX);
               end
            end
            last_fall = n;
            de_cnt = 0;
         end
         if (!LCD_HSYNC) hs_run++;
         if (!hs_prev && LCD_HSYNC) begin
            vectors++;
            if (hs_run !== HS) begin
               miscompares++;
               $display("FAIL hsync_width got %0d exp %0d", hs_run, HS);
            end
            hs_run = 0;
         end
         if (LCD_DE) de_cnt++;
         vs_prev = LCD_VSYNC;
         hs_prev = LCD_HSYNC;
         step(0);
      end
   endtask

   task automatic test_stream(input int junk, input bit solid);
      step(1);
      q.delete();
      for (int i = 0; i < junk; i++) q.push_back({1'b0, 16'($urandom)});
      q.push_back(17'h10000);
      for (int i = 0; i < NPIX; i++) begin
         img1[i] = solid ? 16'hF800 : 16'($urandom);
         q.push_back({1'b0, img1[i]});
      end
      f1 = 1; cut1 = NPIX; f2 = -1; pops = 0;
      step(1); step(0);
      for (int i = 0; i < 3 * FT + 4; i++) begin
         vectors += 3;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== {exp_de(n), exp_hs(n), exp_vs(n)}) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL stream_sync n=%0d", n);
         end
         if ({LCD_R, LCD_G, LCD_B} !== exp_pix(n)) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL stream_pix n=%0d got %h exp %h", n, {LCD_R, LCD_G, LCD_B}, exp_pix(n));
         end
         if (queue_rd_en && queue_empty) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL stream_pop_empty n=%0d rd_en 1 exp 0", n);
         end
         step(0);
      end
      vectors++;
      if (pops !== junk + 1 + NPIX) begin
         miscompares++;
         $display("FAIL stream_pops got %0d exp %0d", pops, junk + 1 + NPIX);
      end
   endtask

   task automatic test_underrun();
      int p;
      p = $urandom_range(1, NPIX - 2);
      step(1);
      q.delete();
      q.push_back(17'h10000);
      for (int i = 0; i < NPIX; i++) begin
         img1[i] = 16'($urandom);
         q.push_back({1'b0, img1[i]});
      end
      q.push_back(17'h10000);
      for (int i = 0; i < NPIX; i++) begin
         img2[i] = 16'($urandom);
         q.push_back({1'b0, img2[i]});
      end
      f1 = 1; cut1 = p; f2 = 2; cut2 = NPIX; pops = 0;
      fe_lo = FT + (p / W) * HT + (p % W);
      fe_hi = FT + H * HT;
      step(1); step(0);
      for (int i = 0; i < 3 * FT + 4; i++) begin
         vectors += 3;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== {exp_de(n), exp_hs(n), exp_vs(n)}) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL under_sync n=%0d", n);
         end
         if ({LCD_R, LCD_G, LCD_B} !== exp_pix(n)) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL under_pix n=%0d p=%0d got %h exp %h", n, p, {LCD_R, LCD_G, LCD_B}, exp_pix(n));
         end
         if (queue_rd_en && queue_empty) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL under_pop_empty n=%0d rd_en 1 exp 0", n);
         end
         step(0);
      end
      fe_lo = 0; fe_hi = 0;
      vectors++;
      if (pops !== 2 + 2 * NPIX) begin
         miscompares++;
         $display("FAIL under_pops got %0d exp %0d", pops, 2 + 2 * NPIX);
      end
   endtask

   task automatic test_resync();
      int k;
      k = $urandom_range(1, NPIX - 4);
      step(1);
      q.delete();
      q.push_back(17'h10000);
      for (int i = 0; i < k; i++) begin
         img1[i] = 16'($urandom);
         q.push_back({1'b0, img1[i]});
      end
      q.push_back(17'h10000);
      for (int i = 0; i < NPIX; i++) begin
         img2[i] = 16'($urandom);
         q.push_back({1'b0, img2[i]});
      end
      f1 = 1; cut1 = k; f2 = 2; cut2 = NPIX; pops = 0;
      step(1); step(0);
      for (int i = 0; i < 3 * FT + 4; i++) begin
         vectors += 2;
         if ({LCD_R, LCD_G, LCD_B} !== exp_pix(n)) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL resync_pix n=%0d k=%0d got %h exp %h", n, k, {LCD_R, LCD_G, LCD_B}, exp_pix(n));
         end
         if (queue_rd_en && queue_empty) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL resync_pop_empty n=%0d rd_en 1 exp 0", n);
         end
         step(0);
      end
      vectors++;
      if (pops !== 2 + k + NPIX) begin
         miscompares++;
         $display("FAIL resync_pops got %0d exp %0d", pops, 2 + k + NPIX);
      end
   endtask

   task automatic test_reset_mid();
      step(1);
      q.delete();
      q.push_back(17'h10000);
      for (int i = 0; i < NPIX; i++) begin
         img1[i] = 16'($urandom);
         q.push_back({1'b0, img1[i]});
      end
      f1 = 1; cut1 = NPIX; f2 = -1;
      step(1); step(0);
      while (n < FT + HT + 7) begin
         vectors++;
         if ({LCD_R, LCD_G, LCD_B} !== exp_pix(n)) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL rmid_pre_pix n=%0d got %h exp %h", n, {LCD_R, LCD_G, LCD_B}, exp_pix(n));
         end
         step(0);
      end
      step(1);
      vectors++;
      if (queue_rd_en !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_rd_in_reset got %b exp 0", queue_rd_en);
      end
      f1 = -1;
      step(0);
      vectors++;
      if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B} !== {3'b011, 16'h0}) begin
         miscompares++;
         $display("FAIL rmid_outputs got %b exp 011 and 0", {LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B});
      end
      for (int i = 0; i < 3 * FT; i++) begin
         if (n == 10) begin
            q.push_back(17'h10000);
            for (int j = 0; j < NPIX; j++) begin
               img1[j] = 16'($urandom);
               q.push_back({1'b0, img1[j]});
            end
            f1 = 1; cut1 = NPIX;
         end
         vectors += 3;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== {exp_de(n), exp_hs(n), exp_vs(n)}) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL rmid_sync n=%0d", n);
         end
         if ({LCD_R, LCD_G, LCD_B} !== exp_pix(n)) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL rmid_pix n=%0d got %h exp %h", n, {LCD_R, LCD_G, LCD_B}, exp_pix(n));
         end
         if (queue_rd_en && queue_empty) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL rmid_pop_empty n=%0d rd_en 1 exp 0", n);
         end
         step(0);
      end
      vectors++;
      if (q.size() !== 0) begin
         miscompares++;
         $display("FAIL rmid_drain got %0d words left exp 0", q.size());
      end
   endtask

   task automatic test_pattern();
      step(1);
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back({1'b1, 16'($urandom)});
      step(1); step(0);
      for (int i = 0; i < FT + 4; i++) begin
         vectors += 3;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== {exp_de(n), exp_hs(n), exp_vs(n)}) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL pat_sync n=%0d", n);
         end
         if ({LCD_R, LCD_G, LCD_B} !== exp_pix(n)) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL pat_pix n=%0d got %h exp %h", n, {LCD_R, LCD_G, LCD_B}, exp_pix(n));
         end
         if (queue_rd_en !== 1'b0) begin
            miscompares++;
            if (miscompares < 20) $display("FAIL pat_pop n=%0d got 1 exp 0", n);
         end
         step(0);
      end
   endtask

   initial begin
      reset_p = 1'b1;
      queue_empty = 1'b1;
      queue_data_in = '0;
      test_reset();
`ifdef LCD_TEST_PATTERN_EN
      test_pattern();
`else
      test_timing();
      test_stream(3, 1'b1);
      test_stream($urandom_range(0, 5), 1'b0);
      test_underrun();
      test_resync();
      test_reset_mid();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
